fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor types and constants: the IF/ID record, the bubble value and the instruction width.
// Imported by fetch_unit and pc_reg.
package fetch_unit_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

    // Branch targets are forced onto a word boundary before they reach the PC.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return {target[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with asynchronous active-high reset and load enable.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic [XLEN-1:0] pc_d_i,
    output logic [XLEN-1:0] pc_q_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC selection, imem addressing and the IF/ID pipeline register.
// Define FETCH_PERF_EN to add the fetch/stall performance counters and their ports.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               pc_src_i,
    input  logic [63:0]        branch_target_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_q_i,
    output logic               ifid_valid_o,
    output logic [63:0]        ifid_pc_o,
    output logic [31:0]        ifid_instr_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_stall_o
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_en;
    ifid_t           ifid_q;
    ifid_t           ifid_d;
    logic            do_fetch;
    logic            do_hold;

    // Redirect wins over stall; a stall alone freezes both PC and IF/ID.
    assign do_fetch = !pc_src_i && !stall_i;
    assign do_hold  = !pc_src_i &&  stall_i;
    assign pc_en    = !do_hold;

    always_comb begin
        pc_d = pc_q + 64'd4;
        if (pc_src_i) begin
            pc_d = align_target(branch_target_i);
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .en_i   (pc_en),
        .pc_d_i (pc_d),
        .pc_q_o (pc_q)
    );

    // Addresses beyond the imem range alias by dropping the high PC bits.
    assign imem_addr_o = pc_q[IMEM_AW+1:2];

    always_comb begin
        ifid_d = ifid_q;
        if (pc_src_i) begin
            ifid_d = IFID_BUBBLE;
        end else if (!stall_i) begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = pc_q;
            ifid_d.instr = imem_q_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_q <= IFID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_valid_o = ifid_q.valid;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_instr_o = ifid_q.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_fetch_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (do_fetch) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (do_hold) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural fetch model compared every negedge,
// plus directed literal checks of the documented scenarios.
module tb_fetch_unit;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_i;
    logic          pc_src_i;
    logic [63:0]   branch_target_i;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_q_i;
    logic          ifid_valid_o;
    logic [63:0]   ifid_pc_o;
    logic [31:0]   ifid_instr_o;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch_o;
    logic [31:0]   perf_stall_o;
`endif

    logic [31:0] imem [64];
    assign imem_q_i = imem[imem_addr_o];

    fetch_unit #(
        .RESET_PC (64'h0),
        .IMEM_AW  (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .pc_src_i        (pc_src_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_q_i        (imem_q_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o    (perf_fetch_o),
        .perf_stall_o    (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic [63:0] m_ifpc;
    logic [31:0] m_instr;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
    logic        cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 64'h0;
        m_valid = 1'b0;
        m_ifpc  = 64'h0;
        m_instr = 32'h0;
        m_fetch = 32'h0;
        m_stall = 32'h0;
    endtask

    // Apply inputs for one edge, advance the model by the fetch rules, then settle.
    task automatic step(input logic st, input logic src, input logic [63:0] tgt);
        int idx;
        stall_i         = st;
        pc_src_i        = src;
        branch_target_i = tgt;
        @(posedge clk);
        if (!reset) begin
            if (src) begin
                m_pc    = tgt - (tgt % 4);
                m_valid = 1'b0;
                m_ifpc  = 64'h0;
                m_instr = 32'h0;
            end else if (st) begin
                m_stall = m_stall + 1;
            end else begin
                idx     = int'((m_pc / 4) % 64);
                m_valid = 1'b1;
                m_ifpc  = m_pc;
                m_instr = imem[idx];
                m_pc    = m_pc + 64'd4;
                m_fetch = m_fetch + 1;
            end
        end
        #1;
        $display("step t=%0t stall=%0b src=%0b tgt=%h -> addr=%0d valid=%0b pc=%h instr=%h",
                 $time, st, src, tgt, imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_instr_o);
    endtask

    // Single compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_addr",  {58'h0, imem_addr_o}, 64'((m_pc / 4) % 64));
            chk("model_valid", {63'h0, ifid_valid_o}, {63'h0, m_valid});
            chk("model_pc",    ifid_pc_o, m_ifpc);
            chk("model_instr", {32'h0, ifid_instr_o}, {32'h0, m_instr});
`ifdef FETCH_PERF_EN
            chk("model_pfetch", {32'h0, perf_fetch_o}, {32'h0, m_fetch});
            chk("model_pstall", {32'h0, perf_stall_o}, {32'h0, m_stall});
`endif
        end
    end

    logic        tb_st  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tb_src [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] tb_tgt [8] = '{64'h0, 64'hAA, 64'h1F3, 64'h55, 64'h0, 64'h1_0000_0010, 64'h2C, 64'h99};

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'hC0DE_0000 | 32'(i);
        imem[0]  = 32'hf8000001;
        imem[1]  = 32'hf8008002;
        imem[2]  = 32'hf8000203;
        imem[29] = 32'hb4000040;

        reset = 1'b1; stall_i = 1'b0; pc_src_i = 1'b0; branch_target_i = 64'h0;
        model_reset();
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {63'h0, ifid_valid_o}, 64'h0);
        chk("rst_pc",    ifid_pc_o, 64'h0);
        chk("rst_instr", {32'h0, ifid_instr_o}, 64'h0);
        chk("rst_addr",  {58'h0, imem_addr_o}, 64'h0);

        @(negedge clk); #1 reset = 1'b0;
        chk("rel_valid0", {63'h0, ifid_valid_o}, 64'h0);

        // Straight-line fetch
        step(1'b0, 1'b0, 64'h0);
        chk("f1_addr",  {58'h0, imem_addr_o}, 64'd1);
        chk("f1_instr", {32'h0, ifid_instr_o}, 64'hf8000001);
        chk("f1_pc",    ifid_pc_o, 64'h0);
        step(1'b0, 1'b0, 64'h0);
        chk("f2_addr",  {58'h0, imem_addr_o}, 64'd2);
        chk("f2_instr", {32'h0, ifid_instr_o}, 64'hf8008002);
        chk("f2_pc",    ifid_pc_o, 64'h4);

        // Three-cycle stall at PC=0x8
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 64'hFFFF_0000_1234_5678);
            chk("stall_addr",  {58'h0, imem_addr_o}, 64'd2);
            chk("stall_pc",    ifid_pc_o, 64'h4);
            chk("stall_instr", {32'h0, ifid_instr_o}, 64'hf8008002);
        end
        step(1'b0, 1'b0, 64'h0);
        chk("resume_instr", {32'h0, ifid_instr_o}, 64'hf8000203);
        chk("resume_addr",  {58'h0, imem_addr_o}, 64'd3);

        // Taken branch to 0x74
        step(1'b0, 1'b1, 64'h74);
        chk("br_valid", {63'h0, ifid_valid_o}, 64'h0);
        chk("br_addr",  {58'h0, imem_addr_o}, 64'd29);
        step(1'b0, 1'b0, 64'hDEAD_BEEF_0000_0000);
        chk("br_instr", {32'h0, ifid_instr_o}, 64'hb4000040);
        chk("br_pc",    ifid_pc_o, 64'h74);

        // Redirect with simultaneous stall, unaligned target
        step(1'b1, 1'b1, 64'h77);
        chk("brst_addr",  {58'h0, imem_addr_o}, 64'd29);
        chk("brst_valid", {63'h0, ifid_valid_o}, 64'h0);
        chk("brst_instr", {32'h0, ifid_instr_o}, 64'h0);

        // imem aliasing at PC=0xFC
        step(1'b0, 1'b1, 64'hFC);
        chk("alias_addr63", {58'h0, imem_addr_o}, 64'd63);
        step(1'b0, 1'b0, 64'h0);
        chk("alias_addr0", {58'h0, imem_addr_o}, 64'd0);
        chk("alias_pc",    ifid_pc_o, 64'hFC);

        // 64-bit PC wraparound
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        step(1'b0, 1'b0, 64'h0);
        chk("wrap_pc",   ifid_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", {58'h0, imem_addr_o}, 64'd0);

        // Mixed directed table, checked by the model
        for (int i = 0; i < 8; i++) step(tb_st[i], tb_src[i], tb_tgt[i]);

        // Reset asserted between edges mid-run
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("mrst_valid", {63'h0, ifid_valid_o}, 64'h0);
        chk("mrst_pc",    ifid_pc_o, 64'h0);
        chk("mrst_instr", {32'h0, ifid_instr_o}, 64'h0);
        chk("mrst_addr",  {58'h0, imem_addr_o}, 64'h0);
`ifdef FETCH_PERF_EN
        chk("mrst_pfetch", {32'h0, perf_fetch_o}, 64'h0);
        chk("mrst_pstall", {32'h0, perf_stall_o}, 64'h0);
`endif
        step(1'b0, 1'b1, 64'h40);
        @(negedge clk); #1 reset = 1'b0;
        chk("mrel_valid0", {63'h0, ifid_valid_o}, 64'h0);
        step(1'b0, 1'b0, 64'h0);
        chk("mrel_valid", {63'h0, ifid_valid_o}, 64'h1);
        chk("mrel_pc",    ifid_pc_o, 64'h0);
        chk("mrel_instr", {32'h0, ifid_instr_o}, 64'hf8000001);
        step(1'b0, 1'b0, 64'h0);
        chk("mrel_pc2", ifid_pc_o, 64'h4);

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
